// File: rtl/scan_pkg.sv
// Shared types for the scan configuration segment: FSM state encoding and counter sizing.
// Contains no logic, so there is no latency or backpressure to describe.
package scan_pkg;

  typedef enum logic [1:0] {
    SCAN_IDLE,
    SCAN_SHIFT,
    SCAN_COMMIT
  } scan_state_t;

  // The counter must be able to hold WIDTH+1, so that an overlong load is distinguishable.
  function automatic int scan_cnt_w(input int width);
    return $clog2(width + 2);
  endfunction

endpackage

// File: rtl/scan_sat_cnt.sv
// Saturating up-counter. Clears and increments on the falling edge.
// A clear together with an increment restarts the count at 1. It holds at MAX and has no backpressure.
module scan_sat_cnt #(
  parameter int W   = 4,
  parameter int MAX = 9
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_clr,
  input  logic         i_inc,
  output logic [W-1:0] o_cnt
);

  logic [W-1:0] r_cnt;

  always_ff @(negedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= i_inc ? W'(1) : '0;
    end else if (i_inc && (r_cnt != W'(MAX))) begin
      r_cnt <= r_cnt + W'(1);
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/scan_cfg_seg.sv
// Scan config segment. Shifts 1 bit/falling edge; cfg_out commits 2 edges after scan_en drops and only if exactly WIDTH bits were shifted.
// There is no backpressure. SCAN_CAPTURE_EN adds a parallel capture into the shift register while idle, for status readback.
module scan_cfg_seg
  import scan_pkg::*;
#(
  parameter int               WIDTH     = 16,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             scan_en,
  input  logic             scan_in,
`ifdef SCAN_CAPTURE_EN
  input  logic             capture_en,
  input  logic [WIDTH-1:0] capture_data,
`endif
  output logic             scan_out,
  output logic [WIDTH-1:0] cfg_out,
  output logic             cfg_valid,
  output logic             shift_err,
  output logic             busy
);

  localparam int            CW       = scan_cnt_w(WIDTH);
  localparam logic [CW-1:0] CNT_FULL = CW'(WIDTH);

  scan_state_t      r_state;
  logic [WIDTH-1:0] r_sr;
  logic [WIDTH-1:0] r_cfg;
  logic             r_vld;
  logic             r_err;
  logic             r_busy;

  logic [CW-1:0]    w_cnt;
  logic             w_clr;
  logic [WIDTH:0]   w_cat;

  assign w_cat = {scan_in, r_sr};
  assign w_clr = (r_state == SCAN_COMMIT) ||
                 ((r_state == SCAN_SHIFT) && !scan_en && (w_cnt != CNT_FULL));

  // Every state shifts while scan_en is high, so the counter increments on scan_en alone.
  scan_sat_cnt #(
    .W   (CW),
    .MAX (WIDTH + 1)
  ) u_cnt (
    .clk   (clk),
    .reset (reset),
    .i_clr (w_clr),
    .i_inc (scan_en),
    .o_cnt (w_cnt)
  );

  always_ff @(negedge clk or posedge reset) begin
    if (reset) begin
      r_sr <= RESET_VAL;
    end else if (scan_en) begin
      r_sr <= w_cat[WIDTH:1];
`ifdef SCAN_CAPTURE_EN
    end else if ((r_state == SCAN_IDLE) && capture_en) begin
      r_sr <= capture_data;
`endif
    end
  end

  always_ff @(negedge clk or posedge reset) begin
    if (reset) begin
      r_state <= SCAN_IDLE;
      r_cfg   <= RESET_VAL;
      r_vld   <= 1'b0;
      r_err   <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_vld <= 1'b0;
      case (r_state)
        SCAN_IDLE: begin
          if (scan_en) begin
            r_state <= SCAN_SHIFT;
            r_busy  <= 1'b1;
          end
        end
        SCAN_SHIFT: begin
          if (!scan_en) begin
            if (w_cnt == CNT_FULL) begin
              r_state <= SCAN_COMMIT;
              r_busy  <= 1'b1;
            end else begin
              r_err   <= 1'b1;
              r_state <= SCAN_IDLE;
              r_busy  <= 1'b0;
            end
          end
        end
        SCAN_COMMIT: begin
          // r_sr is sampled before any shift on this same edge.
          r_cfg   <= r_sr;
          r_vld   <= 1'b1;
          r_err   <= 1'b0;
          r_state <= scan_en ? SCAN_SHIFT : SCAN_IDLE;
          r_busy  <= scan_en;
        end
        default: begin
          r_state <= SCAN_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign scan_out  = r_sr[0];
  assign cfg_out   = r_cfg;
  assign cfg_valid = r_vld;
  assign shift_err = r_err;
  assign busy      = r_busy;

endmodule

// File: tb/tb_scan_cfg_seg.sv
// Directed bench for scan_cfg_seg with WIDTH=8. Inputs are driven on the rising edge and outputs are checked on the next rising edge.
// Define SCAN_CAPTURE_EN to build the bench against the capture variant.
module tb_scan_cfg_seg;
  import scan_pkg::*;

  typedef struct {
    logic       rst;
    logic       en;
    logic       din;
    logic [7:0] cfg;
    logic       so;
    logic       vld;
    logic       err;
    logic       busy;
    bit         ccnt;
    logic [3:0] cnt;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       scan_en = 1'b0;
  logic       scan_in = 1'b0;
  logic       scan_out;
  logic [7:0] cfg_out;
  logic       cfg_valid;
  logic       shift_err;
  logic       busy;
`ifdef SCAN_CAPTURE_EN
  logic       capture_en = 1'b0;
  logic [7:0] capture_data = 8'h00;
`endif

  vec_t vq[$];
  int   n_vec = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  scan_cfg_seg #(
    .WIDTH     (8),
    .RESET_VAL (8'h00)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .scan_en      (scan_en),
    .scan_in      (scan_in),
`ifdef SCAN_CAPTURE_EN
    .capture_en   (capture_en),
    .capture_data (capture_data),
`endif
    .scan_out     (scan_out),
    .cfg_out      (cfg_out),
    .cfg_valid    (cfg_valid),
    .shift_err    (shift_err),
    .busy         (busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic push(input logic rst, input logic en, input logic din, input logic [7:0] cfg,
                      input logic so, input logic vld, input logic err, input logic bsy,
                      input bit ccnt, input logic [3:0] cnt);
    vec_t v;
    v.rst = rst; v.en = en; v.din = din; v.cfg = cfg;
    v.so = so; v.vld = vld; v.err = err; v.busy = bsy;
    v.ccnt = ccnt; v.cnt = cnt;
    vq.push_back(v);
  endtask

  // Queue n shifts of data, LSB first. While sr still holds old bits, scan_out shows prev[j].
  task automatic push_shift(input logic [15:0] data, input int n, input logic [7:0] prev,
                            input logic [7:0] cfg, input logic err, input bit ccnt);
    for (int j = 1; j <= n; j++) begin
      logic       so;
      logic [3:0] c;
      if (j < 8) so = prev[j];
      else       so = data[j-8];
      c = (j > 9) ? 4'd9 : 4'(j);
      push(1'b0, 1'b1, data[j-1], cfg, so, 1'b0, err, 1'b1, ccnt, c);
    end
  endtask

  task automatic run_vecs(input string tag);
    foreach (vq[i]) begin
      reset   = vq[i].rst;
      scan_en = vq[i].en;
      scan_in = vq[i].din;
      @(posedge clk);
      check($sformatf("%s[%0d] {cfg,so,vld,err,busy}", tag, i),
            {20'd0, cfg_out, scan_out, cfg_valid, shift_err, busy},
            {20'd0, vq[i].cfg, vq[i].so, vq[i].vld, vq[i].err, vq[i].busy});
      if (vq[i].ccnt)
        check($sformatf("%s[%0d] cnt", tag, i), 32'(dut.w_cnt), 32'(vq[i].cnt));
    end
    vq.delete();
  endtask

  initial begin
    @(posedge clk);

    push(1, 0, 0, 8'h00, 0, 0, 0, 0, 1, 4'd0);
    push(0, 0, 0, 8'h00, 0, 0, 0, 0, 1, 4'd0);
    // Clean load of A5: COMMIT state on the first edge after the drop, commit on the second.
    push_shift(16'h00A5, 8, 8'h00, 8'h00, 0, 0);
    push(0, 0, 0, 8'h00, 1, 0, 0, 1, 1, 4'd8);
    push(0, 0, 0, 8'hA5, 1, 1, 0, 0, 1, 4'd0);
    push(0, 0, 0, 8'hA5, 1, 0, 0, 0, 0, 4'd0);
    // Short load of 5 ones: an error, and A5 is kept. sr then becomes FD.
    push_shift(16'h001F, 5, 8'hA5, 8'hA5, 0, 0);
    push(0, 0, 0, 8'hA5, 1, 0, 1, 0, 1, 4'd0);
    push(0, 0, 0, 8'hA5, 1, 0, 1, 0, 0, 4'd0);
    // A good load of 3C clears the sticky error when it commits.
    push_shift(16'h003C, 8, 8'hFD, 8'hA5, 1, 0);
    push(0, 0, 0, 8'hA5, 0, 0, 1, 1, 0, 4'd0);
    push(0, 0, 0, 8'h3C, 0, 1, 0, 0, 0, 4'd0);
    push(0, 0, 0, 8'h3C, 0, 0, 0, 0, 0, 4'd0);
    // Overlong load of 10 bits: cnt saturates at 9 and the load is flagged.
    push_shift(16'h0155, 10, 8'h3C, 8'h3C, 0, 1);
    push(0, 0, 0, 8'h3C, 1, 0, 1, 0, 1, 4'd0);
    push(0, 0, 0, 8'h3C, 1, 0, 1, 0, 0, 4'd0);
    // sr now holds 55. Shift 4 of the bits of a new load.
    push_shift(16'h000F, 4, 8'h55, 8'h3C, 1, 1);
    run_vecs("seq");

    // Reset in mid-shift acts at once, without any edge.
    #2 reset = 1'b1;
    #1;
    check("async rst {cfg,so,vld,err,busy}", {24'd0, cfg_out, scan_out, cfg_valid, shift_err, busy}, 32'h0);
    check("async rst state", 32'(dut.r_state), 32'(SCAN_IDLE));
    check("async rst cnt", 32'(dut.w_cnt), 32'd0);
    @(posedge clk);
    push_shift(16'h00C3, 8, 8'h00, 8'h00, 0, 0);
    push(0, 0, 0, 8'h00, 1, 0, 0, 1, 0, 4'd0);
    push(0, 0, 0, 8'hC3, 1, 1, 0, 0, 0, 4'd0);
    push(0, 0, 0, 8'hC3, 1, 0, 0, 0, 0, 4'd0);
    run_vecs("post_rst");

`ifdef SCAN_CAPTURE_EN
    reset = 1'b1;
    @(posedge clk);
    reset        = 1'b0;
    capture_en   = 1'b1;
    capture_data = 8'h5A;
    @(posedge clk);
    capture_en = 1'b0;
    check("capture {cfg,so,vld,err,busy}", {24'd0, cfg_out, scan_out, cfg_valid, shift_err, busy},
          {24'd0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0});
    check("capture cnt", 32'(dut.w_cnt), 32'd0);
    push_shift(16'h0000, 8, 8'h5A, 8'h00, 0, 0);
    push(0, 0, 0, 8'h00, 0, 0, 0, 1, 0, 4'd0);
    push(0, 0, 0, 8'h00, 0, 1, 0, 0, 0, 4'd0);
    run_vecs("capture");
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/scan_cfg_seg.md
# scan_cfg_seg

Parametrised scan-chain configuration segment for the Eyeriss-v1 scan network. It holds WIDTH configuration bits behind a serial shift register with a shadow (update) register, so the configuration outputs never change mid-shift. A saturating bit counter and a small FSM commit the shifted word only when exactly WIDTH bits were shifted. A malformed load is flagged and the old configuration is kept. Segments daisy-chain through scan_in/scan_out into the chip scan controller.

## Interface
- WIDTH, 16: number of configuration bits in the segment (≥1)
- RESET_VAL, '0: value of cfg_out and of the shift register after reset
- clk  input  1  clock; every flop updates on the falling edge, matching the rest of the scan network
- reset  input  1  reset, asynchronous and active-high
- scan_en  input  1  shift enable; one bit is shifted per falling edge while high
- scan_in  input  1  serial data in, from the previous segment
- scan_out  output  1  serial data out, to the next segment; equals sr[0]
- cfg_out  output  WIDTH  committed configuration; this is the shadow register
- cfg_valid  output  1  one-cycle pulse when cfg_out is updated
- shift_err  output  1  sticky flag: the last load had a wrong bit count
- busy  output  1  high when the FSM state is not IDLE

## Operation
- Shift register sr[WIDTH-1:0]. Each shift does sr <= {scan_in, sr[WIDTH-1:1]}, so the stream is LSB-first: the first bit shifted in lands in bit 0 after WIDTH shifts.
- Bit counter cnt is $clog2(WIDTH+2) bits wide. It increments on each shift and saturates at WIDTH+1, so any overlong load is detected.
- FSM states:
  - IDLE:
    - scan_en=1 → shift, cnt<=1, go to SHIFT.
  - SHIFT:
    - scan_en=1 → shift, cnt++ (saturating).
    - scan_en=0 and cnt==WIDTH → go to COMMIT.
    - scan_en=0 and cnt!=WIDTH → shift_err<=1, cnt<=0, go to IDLE. cfg_out is unchanged.
  - COMMIT:
    - cfg_out<=sr, cfg_valid<=1, shift_err<=0, cnt<=0.
    - Next state is SHIFT if scan_en=1 on this edge, otherwise IDLE.
    - If scan_en=1 on this edge, sr also shifts and cnt<=1. cfg_out takes the pre-shift sr.
- cfg_out changes only in COMMIT and on reset. It is never gated by scan_en.
- cfg_valid is high for exactly one cycle after each commit.
- Reset values: sr=RESET_VAL, cfg_out=RESET_VAL, scan_out=RESET_VAL[0], cfg_valid=0, shift_err=0, busy=0, cnt=0, state=IDLE.

## Timing
- Shift latency: scan_in sampled at falling edge n reaches scan_out after WIDTH falling edges.
- Commit latency:
  - Last shift at edge k.
  - scan_en=0 sampled at edge k+1, state goes to COMMIT.
  - cfg_out updates and cfg_valid rises at edge k+2.
  - cfg_valid falls at edge k+3.
- Error is flagged at edge k+1, and cfg_out does not move.
- Reset mid-shift or in COMMIT clears everything immediately, without waiting for an edge. No commit occurs.
- A zero-length enable is impossible, because entering SHIFT always shifts one bit.

## Configuration
- SCAN_CAPTURE_EN defined:
  - Adds ports capture_en (input, 1) and capture_data (input, WIDTH).
  - In IDLE with scan_en=0 and capture_en=1: sr<=capture_data. cnt, cfg_out and the flags are unaffected.
  - scan_en has priority over capture_en.
  - This allows status readback through scan_out.
- SCAN_CAPTURE_EN undefined: those ports are absent, and sr changes only by shifting and on reset.

## Structure
- Package scan_pkg:
  - scan_state_t enum {SCAN_IDLE, SCAN_SHIFT, SCAN_COMMIT}.
  - Function scan_cnt_w(width) returning $clog2(width+2).
- Sub-module scan_sat_cnt: parametrised saturating counter with clear/increment, instantiated once for cnt.
- Shift register, shadow register and FSM live in scan_cfg_seg.

## Test plan
Benches use WIDTH=8 and RESET_VAL=8'h00.
1. Assert reset → cfg_out=8'h00, scan_out=0, cfg_valid=0, shift_err=0, busy=0.
2. Shift 8'hA5 LSB-first (bits 1,0,1,0,0,1,0,1), then drop scan_en.
   - cfg_out stays 8'h00 during the shift.
   - At the 2nd edge after the drop: cfg_out=8'hA5 and cfg_valid is high for one cycle.
3. Shift only 5 bits.
   - At the next edge after the drop: shift_err=1.
   - cfg_out stays 8'hA5 and there is no cfg_valid.
   - A following correct 8-bit load of 8'h3C gives cfg_out=8'h3C and shift_err=0.
4. Shift 10 bits.
   - cnt saturates at 9 and shift_err=1.
   - During the first 8 shifts, scan_out replays the prior sr contents LSB-first.
5. Reset pulse after 4 of 8 shifts → immediate reset values and state IDLE. A fresh 8-bit load then commits normally.
6. (SCAN_CAPTURE_EN) Apply capture_data=8'h5A with a one-cycle capture_en, then 8 shifts with scan_in=0.
   - scan_out sequence is 0,1,0,1,1,0,1,0.
   - Afterwards cfg_out=8'h00.
